// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and
// default frame geometry, common to the receiver and transmitter.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int MID_TICK    = 7;
    localparam int BIT_TICKS   = 16;
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is a parameter so idle-high and idle-low lines both start out quiet.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, optional even parity,
// registered data word with parity/framing flags and a one-cycle done strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT      = DEF_DBIT,
    parameter int SB_TICK   = DEF_SB_TICK,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_BIT  = SW'(BIT_TICKS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            perr_q, perr_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        perr_d  = rx_s ^ (^b_q);
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        // Frame is delivered even when flagged; downstream decides.
                        dout_d       = b_q;
                        parity_err_d = perr_q & PARITY_EN;
                        frame_err_d  = ~rx_s;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                        s_d          = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            done_q       <= done_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, parity and framing errors,
// start-bit glitch, back-to-back frames and mid-frame reset.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TP       = 4;
    localparam int BIT_CLKS = 16 * TP;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int tcnt = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            tcnt   = (tcnt == TP - 1) ? 0 : tcnt + 1;
            s_tick = (tcnt == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rx_done_tick) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic align_tick();
        for (int i = 0; i < TP + 1; i++) begin
            @(negedge clk);
            #1;
            if (s_tick) break;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic sbit, input int stop_clks);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = pbit;
        wait_clks(BIT_CLKS);
        rx = sbit;
        wait_clks(stop_clks);
        rx = 1'b1;
        if (stop_clks < BIT_CLKS) wait_clks(BIT_CLKS - stop_clks);
    endtask

    task automatic test_reset();
        wait_clks(3);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", dout); end
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", rx_done_tick); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        reset = 1'b1;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_clean_a5();
        int c0;
        int t0;
        int dt;
        align_tick();
        c0 = done_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, BIT_CLKS);
        dt = done_cyc - t0;
        n_cmp++; if (dout !== 8'hA5) begin n_err++; $display("FAIL a5_dout: got %h want a5", dout); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL a5_perr: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL a5_ferr: got %b want 0", frame_err); end
        n_cmp++; if (done_cnt - c0 !== 1) begin n_err++; $display("FAIL a5_done_count: got %0d want 1", done_cnt - c0); end
        // 2 sync cycles + 10.5 bit times, allowing one tick of phase either way.
        n_cmp++; if (dt < 2 + 168 * TP - TP || dt > 2 + 168 * TP + TP) begin
            n_err++; $display("FAIL a5_latency: got %0d clk want %0d +/- %0d", dt, 2 + 168 * TP, TP);
        end
    endtask

    task automatic test_parity_err();
        int c0;
        align_tick();
        c0 = done_cnt;
        send_frame(8'h01, 1'b0, 1'b1, BIT_CLKS);
        n_cmp++; if (dout !== 8'h01) begin n_err++; $display("FAIL par_dout: got %h want 01", dout); end
        n_cmp++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL par_perr: got %b want 1", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL par_ferr: got %b want 0", frame_err); end
        n_cmp++; if (done_cnt - c0 !== 1) begin n_err++; $display("FAIL par_done_count: got %0d want 1", done_cnt - c0); end
    endtask

    task automatic test_frame_err();
        int c0;
        align_tick();
        c0 = done_cnt;
        // Stop bit low through its mid-point, then the line returns high.
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        n_cmp++; if (dout !== 8'h3C) begin n_err++; $display("FAIL fe_dout: got %h want 3c", dout); end
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL fe_ferr: got %b want 1", frame_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL fe_perr: got %b want 0", parity_err); end
        n_cmp++; if (done_cnt - c0 !== 1) begin n_err++; $display("FAIL fe_done_count: got %0d want 1", done_cnt - c0); end
        wait_clks(BIT_CLKS);
        align_tick();
        c0 = done_cnt;
        send_frame(8'h55, 1'b0, 1'b1, BIT_CLKS);
        n_cmp++; if (dout !== 8'h55) begin n_err++; $display("FAIL rec_dout: got %h want 55", dout); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rec_ferr: got %b want 0", frame_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL rec_perr: got %b want 0", parity_err); end
        n_cmp++; if (done_cnt - c0 !== 1) begin n_err++; $display("FAIL rec_done_count: got %0d want 1", done_cnt - c0); end
    endtask

    task automatic test_glitch();
        int c0;
        align_tick();
        c0 = done_cnt;
        rx = 1'b0;
        wait_clks(4 * TP);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        n_cmp++; if (done_cnt !== c0) begin n_err++; $display("FAIL gl_done_count: got %0d want %0d", done_cnt, c0); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL gl_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        n_cmp++; if (dout !== 8'h55) begin n_err++; $display("FAIL gl_dout: got %h want 55", dout); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL gl_perr: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL gl_ferr: got %b want 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        int c0;
        align_tick();
        c0 = done_cnt;
        send_frame(8'hFF, 1'b0, 1'b1, BIT_CLKS);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL b2b_dout0: got %h want ff", dout); end
        n_cmp++; if (done_cnt - c0 !== 1) begin n_err++; $display("FAIL b2b_count0: got %0d want 1", done_cnt - c0); end
        send_frame(8'h00, 1'b0, 1'b1, BIT_CLKS);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL b2b_dout1: got %h want 00", dout); end
        n_cmp++; if (done_cnt - c0 !== 2) begin n_err++; $display("FAIL b2b_count1: got %0d want 2", done_cnt - c0); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL b2b_perr: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL b2b_ferr: got %b want 0", frame_err); end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        logic [7:0] d;
        d = 8'h81;
        align_tick();
        c0 = done_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        wait_clks(16);
        reset = 1'b0;
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL mr_dout: got %h want 00", dout); end
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL mr_done: got %b want 0", rx_done_tick); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL mr_perr: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mr_ferr: got %b want 0", frame_err); end
        rx = 1'b1;
        wait_clks(10);
        reset = 1'b1;
        wait_clks(BIT_CLKS);
        n_cmp++; if (done_cnt !== c0) begin n_err++; $display("FAIL mr_no_done: got %0d want %0d", done_cnt, c0); end
        align_tick();
        c0 = done_cnt;
        send_frame(8'h42, 1'b0, 1'b1, BIT_CLKS);
        n_cmp++; if (dout !== 8'h42) begin n_err++; $display("FAIL mr42_dout: got %h want 42", dout); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL mr42_perr: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mr42_ferr: got %b want 0", frame_err); end
        n_cmp++; if (done_cnt - c0 !== 1) begin n_err++; $display("FAIL mr42_done_count: got %0d want 1", done_cnt - c0); end
    endtask

    initial begin
        test_reset();
        test_clean_a5();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
